cdr_link_sync: RTL and testbench



---
 rtl/cdr_link_sync.sv | 251 +++++++++++++++++++++++++
 tb/tb_cdr_link_sync.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_link_sync.sv
`default_nettype none
// ============================================================================
// Module   : cdr_link_sync
// Brief    : Receive-side link synchroniser sequencing CDR reset/settle,
//            sync-byte hunt, frame verification and locked payload delivery.
// Revision : 1.0 - initial release
// ============================================================================
module cdr_link_sync #(
    parameter logic [7:0] SYNC_WORD         = 8'hA7,
    parameter int         FRAME_BYTES       = 4,
    parameter int         VERIFY_COUNT      = 2,
    parameter int         MISS_LIMIT        = 3,
    parameter int         CDR_RST_CYCLES    = 4,
    parameter int         SETTLE_BITS       = 64,
    parameter int         HUNT_TIMEOUT_BITS = 1024,
    parameter int         WATCHDOG_CYCLES   = 64
) (
    input  logic       clk_x8,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       cdr_rst,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int c_FL_BITS  = (FRAME_BYTES + 1) * 8;
    localparam int c_PAY_BITS = FRAME_BYTES * 8;

    localparam int c_RST_W  = $clog2(CDR_RST_CYCLES) + 1;
    localparam int c_SET_W  = $clog2(SETTLE_BITS) + 1;
    localparam int c_HUNT_W = $clog2(HUNT_TIMEOUT_BITS) + 1;
    localparam int c_WD_W   = $clog2(WATCHDOG_CYCLES) + 1;
    localparam int c_POS_W  = $clog2(c_FL_BITS) + 1;
    localparam int c_GOOD_W = $clog2(VERIFY_COUNT) + 1;
    localparam int c_MISS_W = $clog2(MISS_LIMIT) + 1;

    localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(CDR_RST_CYCLES - 1);
    localparam logic [c_SET_W-1:0]  c_SET_LAST  = c_SET_W'(SETTLE_BITS - 1);
    localparam logic [c_HUNT_W-1:0] c_HUNT_LAST = c_HUNT_W'(HUNT_TIMEOUT_BITS - 1);
    localparam logic [c_WD_W-1:0]   c_WD_LAST   = c_WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [c_POS_W-1:0]  c_POS_CHECK = c_POS_W'(c_FL_BITS - 1);
    localparam logic [c_POS_W-1:0]  c_POS_PAY   = c_POS_W'(c_PAY_BITS);
    localparam logic [c_POS_W-1:0]  c_POS_FIRST = c_POS_W'(7);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(VERIFY_COUNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_HUNT   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [7:0]          r_sr;
    logic [c_RST_W-1:0]  r_rst_cnt;
    logic [c_SET_W-1:0]  r_set_cnt;
    logic [c_HUNT_W-1:0] r_hunt_cnt;
    logic [3:0]          r_bit_cnt;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_POS_W-1:0]  r_pos;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_MISS_W-1:0] r_miss;

    logic                r_cdr_rst;
    logic                r_locked;
    logic [7:0]          r_data_out;
    logic                r_data_valid;
    logic                r_frame_start;
    logic                r_sync_err;

    logic [7:0]          w_nxt;
    logic                w_sync_hit;
    logic                w_framed;
    logic                w_check_bit;
    logic                w_byte_end;
    logic                w_wd_expire;
    logic                w_hunt_match;
    logic                w_stay;

    // nxt is the byte as it will look once the current bit is shifted in
    assign w_nxt        = {r_sr[6:0], bit_in};
    assign w_sync_hit   = (w_nxt == SYNC_WORD);
    assign w_framed     = (r_state == ST_VERIFY) || (r_state == ST_LOCKED);
    assign w_check_bit  = bit_valid && w_framed && (r_pos == c_POS_CHECK);
    assign w_byte_end   = bit_valid && (r_state == ST_LOCKED) &&
                          (r_pos[2:0] == 3'b111) && (r_pos < c_POS_PAY);
    assign w_wd_expire  = (r_state != ST_RESET) && !bit_valid && (r_wd == c_WD_LAST);
    assign w_hunt_match = bit_valid && (r_state == ST_HUNT) &&
                          (r_bit_cnt >= 4'd7) && w_sync_hit;
    assign w_stay       = (w_next_state == r_state);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bit_valid && (r_set_cnt == c_SET_LAST)) begin
                    w_next_state = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (w_hunt_match) begin
                    w_next_state = (VERIFY_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
                end else if (bit_valid && (r_hunt_cnt == c_HUNT_LAST)) begin
                    w_next_state = ST_RESET;
                end
            end
            ST_VERIFY: begin
                if (w_check_bit) begin
                    if (!w_sync_hit) begin
                        w_next_state = ST_HUNT;
                    end else if (r_good == c_GOOD_LAST) begin
                        w_next_state = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_check_bit && !w_sync_hit && (r_miss == c_MISS_LAST)) begin
                    w_next_state = ST_HUNT;
                end
            end
            default: w_next_state = ST_RESET;
        endcase
        // a stalled bit stream overrides every other transition
        if (w_wd_expire) begin
            w_next_state = ST_RESET;
        end
    end

    always_ff @(posedge clk_x8) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_x8) begin
        if (rst) begin
            r_sr          <= '0;
            r_rst_cnt     <= '0;
            r_set_cnt     <= '0;
            r_hunt_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_wd          <= '0;
            r_pos         <= '0;
            r_good        <= '0;
            r_miss        <= '0;
            r_cdr_rst     <= 1'b1;
            r_locked      <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_cdr_rst     <= (w_next_state == ST_RESET);
            r_locked      <= (w_next_state == ST_LOCKED);
            r_sync_err    <= w_check_bit && !w_sync_hit;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;

            if ((w_next_state == ST_RESET) || ((w_next_state == ST_HUNT) && !w_stay)) begin
                r_sr <= '0;
            end else if (bit_valid) begin
                r_sr <= w_nxt;
            end

            if ((r_state == ST_RESET) && w_stay) begin
                r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end

            if ((r_state == ST_SETTLE) && w_stay) begin
                if (bit_valid) begin
                    r_set_cnt <= r_set_cnt + c_SET_W'(1);
                end
            end else begin
                r_set_cnt <= '0;
            end

            if ((r_state == ST_HUNT) && w_stay) begin
                if (bit_valid && (r_hunt_cnt != c_HUNT_W'(HUNT_TIMEOUT_BITS))) begin
                    r_hunt_cnt <= r_hunt_cnt + c_HUNT_W'(1);
                end
                if (bit_valid && (r_bit_cnt != 4'd8)) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_hunt_cnt <= '0;
                r_bit_cnt  <= '0;
            end

            if (bit_valid || (w_next_state == ST_RESET)) begin
                r_wd <= '0;
            end else if (r_wd != c_WD_LAST) begin
                r_wd <= r_wd + c_WD_W'(1);
            end

            // frame flywheel: pos counts the bit being sampled, wrapping after the sync check
            if ((w_next_state != ST_VERIFY) && (w_next_state != ST_LOCKED)) begin
                r_pos <= '0;
            end else if (w_framed && bit_valid) begin
                r_pos <= (r_pos == c_POS_CHECK) ? '0 : r_pos + c_POS_W'(1);
            end

            if (w_hunt_match) begin
                r_good <= c_GOOD_W'(1);
            end else if (w_next_state != ST_VERIFY) begin
                r_good <= '0;
            end else if (w_check_bit && w_sync_hit) begin
                r_good <= r_good + c_GOOD_W'(1);
            end

            if (w_next_state != ST_LOCKED) begin
                r_miss <= '0;
            end else if ((r_state == ST_LOCKED) && w_check_bit) begin
                r_miss <= w_sync_hit ? '0 : r_miss + c_MISS_W'(1);
            end

            if (w_byte_end) begin
                r_data_out    <= w_nxt;
                r_data_valid  <= 1'b1;
                r_frame_start <= (r_pos == c_POS_FIRST);
            end
        end
    end

    assign state       = r_state;
    assign cdr_rst     = r_cdr_rst;
    assign locked      = r_locked;
    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_start = r_frame_start;
    assign sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_cdr_link_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdr_link_sync
// Brief    : Directed, table-driven self-checking bench for cdr_link_sync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdr_link_sync;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_HUNT   = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    logic       clk_x8 = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       cdr_rst;
    logic       locked;
    logic [2:0] state;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       sync_err;

    int checks = 0;
    int errors = 0;
    int n_dv = 0;
    int n_fs = 0;
    int n_se = 0;

    typedef struct {
        logic [7:0] b;
        logic [2:0] st;
        logic       lk;
        logic       dv;
        logic       fs;
        logic       se;
    } vec_t;

    vec_t vecs[$];

    cdr_link_sync dut (
        .clk_x8      (clk_x8),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .cdr_rst     (cdr_rst),
        .locked      (locked),
        .state       (state),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .sync_err    (sync_err)
    );

    always #5 clk_x8 = ~clk_x8;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one strobe every 8 clocks; pulses are sampled 1 time unit after the strobe edge
    task automatic send_bit(input logic b);
        repeat (7) @(posedge clk_x8);
        #1;
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk_x8);
        #1;
        bit_valid = 1'b0;
        n_dv += int'(data_valid);
        n_fs += int'(frame_start);
        n_se += int'(sync_err);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [2:0] st, input logic lk,
                        input logic dv, input logic fs, input logic se);
        vec_t v;
        v.b  = b;
        v.st = st;
        v.lk = lk;
        v.dv = dv;
        v.fs = fs;
        v.se = se;
        vecs.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] base, input logic [7:0] sync,
                              input logic [2:0] st, input logic lk, input logic se);
        logic [7:0] b;
        b = base;
        push(b, S_LOCKED, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            b = b + 8'd1;
            push(b, S_LOCKED, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        push(sync, st, lk, 1'b0, 1'b0, se);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " state"}, 32'(state), 32'(S_RESET));
        chk({tag, " cdr_rst"}, 32'(cdr_rst), 32'd1);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " data_out"}, 32'(data_out), 32'd0);
        chk({tag, " data_valid"}, 32'(data_valid), 32'd0);
        chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, " sync_err"}, 32'(sync_err), 32'd0);
    endtask

    task automatic count_cdr_rst(input string tag);
        int hi;
        int n;
        hi = 0;
        n  = 0;
        while ((cdr_rst === 1'b1) && (n < 20)) begin
            hi++;
            @(posedge clk_x8);
            #1;
            n++;
        end
        chk({tag, " cdr_rst cycles"}, 32'(hi), 32'd4);
        chk({tag, " state after cdr_rst"}, 32'(state), 32'(S_SETTLE));
    endtask

    task automatic settle_and_check(input string tag);
        for (int i = 0; i < 63; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        chk({tag, " settle bit 63"}, 32'(state), 32'(S_SETTLE));
        send_bit(1'($urandom_range(0, 1)));
        chk({tag, " settle bit 64"}, 32'(state), 32'(S_HUNT));
    endtask

    task automatic lock_seq(input string tag);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA7);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'hA7);
        chk({tag, " locked"}, 32'(locked), 32'd1);
        chk({tag, " state"}, 32'(state), 32'(S_LOCKED));
    endtask

    initial begin
        int n;

        // hunt, verify and lock
        push(8'h00, S_HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h00, S_HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'hA7, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h01, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h02, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h03, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h04, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'hA7, S_LOCKED, 1'b1, 1'b0, 1'b0, 1'b0);
        // locked payload, then misses interleaved with a good sync, then loss of lock
        push_frame(8'h01, 8'hA7, S_LOCKED, 1'b1, 1'b0);
        push_frame(8'h30, 8'h5A, S_LOCKED, 1'b1, 1'b1);
        push_frame(8'h40, 8'hA7, S_LOCKED, 1'b1, 1'b0);
        push_frame(8'h50, 8'h5A, S_LOCKED, 1'b1, 1'b1);
        push_frame(8'h60, 8'h5A, S_LOCKED, 1'b1, 1'b1);
        push_frame(8'h70, 8'h5A, S_HUNT, 1'b0, 1'b1);
        // verify failure
        push(8'h00, S_HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'hA7, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h01, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h02, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h03, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h04, S_VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h5A, S_HUNT, 1'b0, 1'b0, 1'b0, 1'b1);

        rst = 1'b1;
        repeat (3) @(posedge clk_x8);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        count_cdr_rst("bringup");
        settle_and_check("bringup");

        foreach (vecs[i]) begin
            n_dv = 0;
            n_fs = 0;
            n_se = 0;
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].lk));
            chk($sformatf("vec%0d data_valid count", i), 32'(n_dv), 32'(vecs[i].dv));
            chk($sformatf("vec%0d frame_start count", i), 32'(n_fs), 32'(vecs[i].fs));
            chk($sformatf("vec%0d sync_err count", i), 32'(n_se), 32'(vecs[i].se));
            if (vecs[i].dv) begin
                chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].b));
            end
        end

        // hunt timeout after 1024 bits without a sync byte
        for (int i = 0; i < 1023; i++) begin
            send_bit(1'b0);
        end
        chk("hunt bit 1023 state", 32'(state), 32'(S_HUNT));
        send_bit(1'b0);
        chk("hunt timeout state", 32'(state), 32'(S_RESET));
        count_cdr_rst("timeout");
        settle_and_check("retrain");
        lock_seq("relock1");

        // watchdog: bit_valid stops while locked
        n = 0;
        while ((state !== S_RESET) && (n < 200)) begin
            @(posedge clk_x8);
            #1;
            n++;
        end
        chk("watchdog cycles to RESET", 32'(n), 32'd64);
        chk("watchdog cdr_rst", 32'(cdr_rst), 32'd1);

        // rst at frame position 12
        settle_and_check("post_wd");
        lock_seq("relock2");
        n_dv = 0;
        n_fs = 0;
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0);
        end
        chk("midframe data_valid count", 32'(n_dv), 32'd1);
        chk("midframe frame_start count", 32'(n_fs), 32'd1);
        chk("midframe data_out", 32'(data_out), 32'h01);
        rst = 1'b1;
        @(posedge clk_x8);
        #1;
        check_reset_outputs("midframe_rst");
        rst = 1'b0;
        n_dv = 0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0);
        end
        chk("post rst data_valid count", 32'(n_dv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
